scd_slot_packer: RTL and testbench

- Sits directly upstream of the scheduler-to-PHY converter.
- Accepts one decoded DDR command per fabric clock over a valid/ready handshake, each carrying a required trailing NOP gap.
- Places each command into the correct DDR slot of a 4-slot packet, which drives the converter's scd_cmd/scd_row/scd_bank/scd_col buses.
- Enforces slot-level spacing across packet boundaries and the PHY's restriction that CAS commands (RD/WR) occupy only slot 1 or slot 3.

---
 rtl/scd_slot_packer_pkg.sv | 17 +
 rtl/scd_slot_packer_if.sv | 20 ++
 rtl/scd_slot_packer.sv | 88 ++++++++
 tb/tb_scd_slot_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scd_slot_packer_pkg.sv
// Shared DDR command encoding for the scheduler-to-PHY path: field widths,
// one-hot command bit indices and the per-packet slot count.
package scd_slot_packer_pkg;
  localparam int DEC_DDR_CMD_SZ = 7;
  localparam int ROW_SZ         = 16;
  localparam int BANK_SZ        = 3;
  localparam int COL_SZ         = 10;
  localparam int DDR_SLOTS      = 4;

  localparam int CMD_ACT  = 0;
  localparam int CMD_PRE  = 1;
  localparam int CMD_RD   = 2;
  localparam int CMD_WR   = 3;
  localparam int CMD_ZQS  = 4;
  localparam int CMD_REF  = 5;
  localparam int CMD_PREA = 6;
endpackage

// File: rtl/scd_slot_packer_if.sv
// Decoded-command handshake into the slot packer.
// valid/ready: a command transfers on a posedge where in_valid and in_ready
// are both 1; while in_valid is high and in_ready low the master holds every
// in_* field stable, and in_ready may depend combinationally on in_valid.
interface scd_slot_packer_if #(parameter int GAP_W = 6);
  import scd_slot_packer_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [DEC_DDR_CMD_SZ-1:0] in_cmd;
  logic [ROW_SZ-1:0]         in_row;
  logic [BANK_SZ-1:0]        in_bank;
  logic [COL_SZ-1:0]         in_col;
  logic [GAP_W-1:0]          in_gap;

  modport master (output in_valid, in_cmd, in_row, in_bank, in_col, in_gap,
                  input  in_ready);
  modport slave  (input  in_valid, in_cmd, in_row, in_bank, in_col, in_gap,
                  output in_ready);
endinterface

// File: rtl/scd_slot_packer.sv
// Places one decoded DDR command per fabric cycle into a 4-slot packet,
// honouring per-command trailing gaps across packets and CAS odd-slot rules.
module scd_slot_packer
  import scd_slot_packer_pkg::*;
#(
  parameter int GAP_W = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                init_calib_complete,
  input  logic                                phy_mc_cmd_full,
  scd_slot_packer_if.slave                    in_if,
  output logic [DEC_DDR_CMD_SZ*DDR_SLOTS-1:0] scd_cmd,
  output logic [ROW_SZ*DDR_SLOTS-1:0]         scd_row,
  output logic [BANK_SZ*DDR_SLOTS-1:0]        scd_bank,
  output logic [COL_SZ*DDR_SLOTS-1:0]         scd_col,
  output logic [GAP_W:0]                      pending_slots
);
  localparam int EW = GAP_W + 2;

  logic [GAP_W:0]                      r_e;
  logic [DEC_DDR_CMD_SZ*DDR_SLOTS-1:0] r_cmd;
  logic [ROW_SZ*DDR_SLOTS-1:0]         r_row;
  logic [BANK_SZ*DDR_SLOTS-1:0]        r_bank;
  logic [COL_SZ*DDR_SLOTS-1:0]         r_col;

  logic                                w_en;
  logic                                w_cas;
  logic                                w_bump;
  logic [GAP_W:0]                      w_slot;
  logic                                w_accept;
  logic [EW-1:0]                       w_sum;
  logic [GAP_W:0]                      w_e_next;
  logic [DEC_DDR_CMD_SZ*DDR_SLOTS-1:0] w_cmd;
  logic [ROW_SZ*DDR_SLOTS-1:0]         w_row;
  logic [BANK_SZ*DDR_SLOTS-1:0]        w_bank;
  logic [COL_SZ*DDR_SLOTS-1:0]         w_col;

  assign w_en     = rst & init_calib_complete & ~phy_mc_cmd_full;
  assign w_cas    = in_if.in_cmd[CMD_RD] | in_if.in_cmd[CMD_WR];
  // CAS may only sit in an odd slot, so an even candidate slides by one.
  assign w_bump   = w_cas & ~r_e[0];
  assign w_slot   = r_e + {{GAP_W{1'b0}}, w_bump};
  assign w_accept = w_en & in_if.in_valid & (w_slot <= (GAP_W+1)'(3));
  assign in_if.in_ready = w_accept;

  always_comb begin
    w_sum    = EW'(w_slot) + EW'(1) + EW'(in_if.in_gap);
    w_e_next = '0;
    if (w_accept) begin
      if (w_sum >= EW'(DDR_SLOTS)) w_e_next = (GAP_W+1)'(w_sum - EW'(DDR_SLOTS));
    end else if (r_e >= (GAP_W+1)'(DDR_SLOTS)) begin
      // Stalled cycles still burn four slots of gap credit.
      w_e_next = r_e - (GAP_W+1)'(DDR_SLOTS);
    end
  end

  for (genvar k = 0; k < DDR_SLOTS; k++) begin : g_slot
    logic w_hit;
    assign w_hit = w_accept & (w_slot[1:0] == 2'(k));
    assign w_cmd [k*DEC_DDR_CMD_SZ +: DEC_DDR_CMD_SZ] = w_hit ? in_if.in_cmd  : '0;
    assign w_row [k*ROW_SZ         +: ROW_SZ]         = w_hit ? in_if.in_row  : '0;
    assign w_bank[k*BANK_SZ        +: BANK_SZ]        = w_hit ? in_if.in_bank : '0;
    assign w_col [k*COL_SZ         +: COL_SZ]         = w_hit ? in_if.in_col  : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_e    <= '0;
      r_cmd  <= '0;
      r_row  <= '0;
      r_bank <= '0;
      r_col  <= '0;
    end else begin
      r_e    <= w_e_next;
      r_cmd  <= w_cmd;
      r_row  <= w_row;
      r_bank <= w_bank;
      r_col  <= w_col;
    end
  end

  assign scd_cmd       = r_cmd;
  assign scd_row       = r_row;
  assign scd_bank      = r_bank;
  assign scd_col       = r_col;
  assign pending_slots = r_e;
endmodule

// File: tb/tb_scd_slot_packer.sv
// Self-checking bench for scd_slot_packer: directed scenarios plus random
// traffic against an absolute-slot-timeline reference model.
module tb_scd_slot_packer;
  import scd_slot_packer_pkg::*;

  localparam int GAP_W = 6;
  localparam int CW = DEC_DDR_CMD_SZ*DDR_SLOTS;
  localparam int RW = ROW_SZ*DDR_SLOTS;
  localparam int BW = BANK_SZ*DDR_SLOTS;
  localparam int LW = COL_SZ*DDR_SLOTS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init_calib_complete = 1'b1;
  logic phy_mc_cmd_full = 1'b0;
  logic [CW-1:0] scd_cmd;
  logic [RW-1:0] scd_row;
  logic [BW-1:0] scd_bank;
  logic [LW-1:0] scd_col;
  logic [GAP_W:0] pending_slots;

  scd_slot_packer_if #(.GAP_W(GAP_W)) in_if ();

  scd_slot_packer #(.GAP_W(GAP_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .phy_mc_cmd_full     (phy_mc_cmd_full),
    .in_if               (in_if.slave),
    .scd_cmd             (scd_cmd),
    .scd_row             (scd_row),
    .scd_bank            (scd_bank),
    .scd_col             (scd_col),
    .pending_slots       (pending_slots)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute slot numbers. m_nf is the earliest absolute
  // slot the next command may use; packet m_cyc spans slots 4*m_cyc..+3.
  int m_nf  = 0;
  int m_cyc = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_cmd;
  logic [RW-1:0] exp_row;
  logic [BW-1:0] exp_bank;
  logic [LW-1:0] exp_col;
  int  exp_pending;
  bit  exp_ready;
  logic obs_ready;

  task automatic drive(input logic v, input logic [DEC_DDR_CMD_SZ-1:0] c,
                       input int row, input int bank, input int col, input int gap);
    in_if.in_valid = v;
    in_if.in_cmd   = c;
    in_if.in_row   = ROW_SZ'(row);
    in_if.in_bank  = BANK_SZ'(bank);
    in_if.in_col   = COL_SZ'(col);
    in_if.in_gap   = GAP_W'(gap);
  endtask

  // One fabric cycle: sample in_ready mid-cycle, predict, then clock.
  task automatic tick();
    int base, cand;
    bit cas, acc;
    @(negedge clk);
    obs_ready = in_if.in_ready;
    exp_cmd = '0; exp_row = '0; exp_bank = '0; exp_col = '0;
    if (!rst) begin
      exp_ready = 0; m_nf = 0; m_cyc = 0; exp_pending = 0;
    end else begin
      base = 4*m_cyc;
      cand = (m_nf > base) ? m_nf - base : 0;
      cas  = in_if.in_cmd[CMD_RD] | in_if.in_cmd[CMD_WR];
      if (cas && (cand % 2 == 0)) cand++;
      acc = init_calib_complete && !phy_mc_cmd_full && in_if.in_valid && (cand <= 3);
      exp_ready = acc;
      if (acc) begin
        exp_cmd [cand*DEC_DDR_CMD_SZ +: DEC_DDR_CMD_SZ] = in_if.in_cmd;
        exp_row [cand*ROW_SZ +: ROW_SZ]   = in_if.in_row;
        exp_bank[cand*BANK_SZ +: BANK_SZ] = in_if.in_bank;
        exp_col [cand*COL_SZ +: COL_SZ]   = in_if.in_col;
        m_nf = base + cand + 1 + int'(in_if.in_gap);
      end
      m_cyc++;
      exp_pending = (m_nf > 4*m_cyc) ? m_nf - 4*m_cyc : 0;
    end
    exp_q.push_back(exp_cmd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 7'b0000001, 5, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", obs_ready); end
      checks++;
      if (scd_cmd !== exp_q.pop_front() || scd_cmd !== '0)
        begin errors++; $display("FAIL reset_cmd: got %h want 0", scd_cmd); end
      checks++;
      if (pending_slots !== '0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending_slots); end
    end
    rst = 1'b1;
  endtask

  task automatic test_act_wr();
    logic [CW-1:0] e;
    drive(1'b1, 7'b0000001, 'h1A5, 2, 0, 0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL act_ready: got %b want 1", obs_ready); end
    checks++;
    if (scd_cmd !== e || scd_cmd[6:0] !== 7'b0000001) begin errors++; $display("FAIL act_slot0: got %h want %h", scd_cmd, e); end
    checks++;
    if (scd_row[15:0] !== 16'h01A5 || scd_bank[2:0] !== 3'd2)
      begin errors++; $display("FAIL act_addr: got row %h bank %0d want 1a5/2", scd_row[15:0], scd_bank[2:0]); end
    drive(1'b1, 7'b0001000, 0, 2, 'h40, 0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (scd_cmd !== e || scd_cmd[13:7] !== 7'b0001000 || scd_cmd[6:0] !== 7'd0)
      begin errors++; $display("FAIL wr_slot1: got %h want %h", scd_cmd, e); end
    checks++;
    if (scd_col[19:10] !== 10'h040) begin errors++; $display("FAIL wr_col: got %h want 040", scd_col[19:10]); end
    checks++;
    if (pending_slots !== 7'd0) begin errors++; $display("FAIL wr_pending: got %0d want 0", pending_slots); end
  endtask

  task automatic test_cross_gap();
    drive(1'b1, 7'b0000010, 0, 1, 0, 9);
    tick(); void'(exp_q.pop_front());
    checks++;
    if (pending_slots !== 7'd6) begin errors++; $display("FAIL gap_e6: got %0d want 6", pending_slots); end
    drive(1'b1, 7'b0000001, 'h33, 1, 0, 0);
    tick();
    checks++;
    if (obs_ready !== 1'b0 || scd_cmd !== exp_q.pop_front() || scd_cmd !== '0)
      begin errors++; $display("FAIL gap_idle: got ready %b cmd %h want 0/0", obs_ready, scd_cmd); end
    checks++;
    if (pending_slots !== 7'd2) begin errors++; $display("FAIL gap_e2: got %0d want 2", pending_slots); end
    tick();
    checks++;
    if (obs_ready !== 1'b1 || scd_cmd !== exp_q.pop_front() || scd_cmd[20:14] !== 7'b0000001)
      begin errors++; $display("FAIL gap_act_slot2: got ready %b cmd %h", obs_ready, scd_cmd); end
  endtask

  task automatic test_cas_slot3();
    drive(1'b1, 7'b0000000, 0, 0, 0, 6);
    tick(); void'(exp_q.pop_front());
    checks++;
    if (pending_slots !== 7'd3) begin errors++; $display("FAIL cas_setup_e3: got %0d want 3", pending_slots); end
    drive(1'b1, 7'b0000100, 0, 4, 'h11, 0);
    tick();
    checks++;
    if (scd_cmd !== exp_q.pop_front() || scd_cmd[27:21] !== 7'b0000100 || pending_slots !== 7'd0)
      begin errors++; $display("FAIL cas_slot3: got cmd %h e %0d", scd_cmd, pending_slots); end
    drive(1'b1, 7'b0000100, 0, 5, 'h22, 0);
    tick();
    checks++;
    if (scd_cmd !== exp_q.pop_front() || scd_cmd[13:7] !== 7'b0000100 || scd_col[19:10] !== 10'h022)
      begin errors++; $display("FAIL cas_next_slot1: got cmd %h col %h", scd_cmd, scd_col); end
  endtask

  task automatic test_stall();
    drive(1'b1, 7'b0000000, 0, 0, 0, 8);
    tick(); void'(exp_q.pop_front());
    checks++;
    if (pending_slots !== 7'd5) begin errors++; $display("FAIL stall_e5: got %0d want 5", pending_slots); end
    drive(1'b1, 7'b0100000, 0, 0, 0, 0);
    phy_mc_cmd_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_ready !== 1'b0 || scd_cmd !== exp_q.pop_front() || pending_slots !== 7'(exp_pending))
        begin errors++; $display("FAIL stall_cycle%0d: got ready %b e %0d want 0/%0d", i, obs_ready, pending_slots, exp_pending); end
    end
    checks++;
    if (pending_slots !== 7'd0) begin errors++; $display("FAIL stall_e0: got %0d want 0", pending_slots); end
    phy_mc_cmd_full = 1'b0;
    tick();
    checks++;
    if (obs_ready !== 1'b1 || scd_cmd !== exp_q.pop_front() || scd_cmd[6:0] !== 7'b0100000)
      begin errors++; $display("FAIL stall_release: got ready %b cmd %h", obs_ready, scd_cmd); end
  endtask

  task automatic test_calib();
    init_calib_complete = 1'b0;
    drive(1'b1, 7'b0001000, 0, 3, 'h7, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_ready !== 1'b0 || scd_cmd !== exp_q.pop_front() || scd_cmd !== '0)
        begin errors++; $display("FAIL calib_block%0d: got ready %b cmd %h", i, obs_ready, scd_cmd); end
    end
    init_calib_complete = 1'b1;
    tick();
    checks++;
    if (obs_ready !== 1'b1 || scd_cmd !== exp_q.pop_front() || scd_cmd[13:7] !== 7'b0001000)
      begin errors++; $display("FAIL calib_resume: got ready %b cmd %h", obs_ready, scd_cmd); end
  endtask

  task automatic test_random();
    logic [CW-1:0] e;
    int k, gap;
    bit hold;
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        k   = $urandom_range(0, 7);
        gap = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 10);
        drive($urandom_range(0, 3) != 0, (k == 7) ? 7'd0 : 7'(1 << k),
              $urandom, $urandom, $urandom, gap);
      end
      phy_mc_cmd_full     = ($urandom_range(0, 7) == 0);
      init_calib_complete = ($urandom_range(0, 15) != 0);
      rst                 = ($urandom_range(0, 63) != 0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
      checks++;
      if (scd_cmd !== e) begin errors++; $display("FAIL rnd_cmd[%0d]: got %h want %h", n, scd_cmd, e); end
      checks++;
      if (scd_row !== exp_row || scd_bank !== exp_bank || scd_col !== exp_col)
        begin errors++; $display("FAIL rnd_addr[%0d]: got %h/%h/%h want %h/%h/%h", n, scd_row, scd_bank, scd_col, exp_row, exp_bank, exp_col); end
      checks++;
      if (pending_slots !== 7'(exp_pending)) begin errors++; $display("FAIL rnd_pending[%0d]: got %0d want %0d", n, pending_slots, exp_pending); end
      hold = in_if.in_valid && !exp_ready && rst;
    end
    rst = 1'b1; phy_mc_cmd_full = 1'b0; init_calib_complete = 1'b1;
  endtask

  initial begin
    drive(1'b0, 7'd0, 0, 0, 0, 0);
    test_reset();
    test_act_wr();
    test_cross_gap();
    test_cas_slot3();
    test_stall();
    test_calib();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
